// File: rtl/noc_pkg.sv
// Shared router definitions: flit layout and the steering decision used by
// every route-compute stage in the node.
package noc_pkg;

  localparam int FLIT_W  = 11;
  localparam int DEST_HI = 10;
  localparam int DEST_LO = 8;
  localparam int DEST_W  = DEST_HI - DEST_LO + 1;

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [DEST_W-1:0] dest_t;

  // 0 keeps the flit inside this node's subtree (port 1), 1 sends it onward (port 2).
  function automatic logic route_bit(input dest_t dest, input dest_t node_id,
                                     input dest_t mask);
    return ((dest & mask) == (node_id & mask)) ? 1'b0 : 1'b1;
  endfunction

endpackage

// File: rtl/route_compute_2_if.sv
// Flit channels around the route-compute stage: upstream valid/ready input and
// the data+control transfer toward the split stage.
interface route_compute_2_if;
  import noc_pkg::*;

  logic  in_valid;
  logic  in_ready;
  flit_t in_data;
  logic  out_valid;
  logic  out_ready;
  flit_t out_data;
  logic  out_ctrl;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

endinterface

// File: rtl/flit_fifo.sv
// Register-array synchronous FIFO for flits; the caller guarantees no push
// when full and no pop when empty.
module flit_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  flit_t                  din,
  output flit_t                  dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  flit_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/route_compute_2.sv
// Input buffer plus route compute ahead of the two-way split: buffers flits,
// tags the head with its steering bit and counts deliveries per direction.
module route_compute_2
  import noc_pkg::*;
#(
  parameter logic [2:0] NODE_ID    = 3'd0,
  parameter logic [2:0] LEVEL_MASK = 3'b110,
  parameter int         DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    _RESET,
  route_compute_2_if.slave        io,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [15:0]             cnt_port1,
  output logic [15:0]             cnt_port2
);

  logic  full;
  logic  empty;
  logic  push;
  logic  pop;
  flit_t head;

  // No full-bypass: a full buffer refuses input even while it is draining.
  assign io.in_ready  = !full;
  assign io.out_valid = !empty;
  assign push         = io.in_valid && io.in_ready;
  assign pop          = io.out_valid && io.out_ready;

  flit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (_RESET),
    .push  (push),
    .pop   (pop),
    .din   (io.in_data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  assign io.out_data = head;
  assign io.out_ctrl = route_bit(head[DEST_HI:DEST_LO], NODE_ID, LEVEL_MASK);

  always_ff @(posedge clk or negedge _RESET) begin
    if (!_RESET) begin
      cnt_port1 <= '0;
      cnt_port2 <= '0;
    end else if (pop) begin
      if (io.out_ctrl) cnt_port2 <= cnt_port2 + 16'd1;
      else             cnt_port1 <= cnt_port1 + 16'd1;
    end
  end

endmodule

// File: tb/tb_route_compute_2.sv
// Directed bench for route_compute_2 with NODE_ID=0, LEVEL_MASK=3'b110, DEPTH=4.
module tb_route_compute_2;

  logic        clk;
  logic        rst_n;
  logic [2:0]  occupancy;
  logic [15:0] cnt_port1;
  logic [15:0] cnt_port2;
  int          tests;
  int          fails;

  route_compute_2_if bus ();

  route_compute_2 #(
    .NODE_ID    (3'd0),
    .LEVEL_MASK (3'b110),
    .DEPTH      (4)
  ) dut (
    .clk       (clk),
    ._RESET    (rst_n),
    .io        (bus),
    .occupancy (occupancy),
    .cnt_port1 (cnt_port1),
    .cnt_port2 (cnt_port2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [10:0] fill [4];
    logic [10:0] sflit;
    tests = 0;
    fails = 0;
    fill[0] = 11'h010; fill[1] = 11'h121; fill[2] = 11'h232; fill[3] = 11'h343;

    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_occupancy", 32'(occupancy),     32'd0);
    chk("rst_cnt1",      32'(cnt_port1),     32'd0);
    chk("rst_cnt2",      32'(cnt_port2),     32'd0);
    rst_n = 1'b1;
    tick();

    // Single flit to dest 1: local subtree.
    bus.in_valid = 1'b1; bus.in_data = 11'h1A5;
    tick();
    bus.in_valid = 1'b0;
    chk("single_valid", 32'(bus.out_valid), 32'd1);
    chk("single_data",  32'(bus.out_data),  32'h1A5);
    chk("single_ctrl",  32'(bus.out_ctrl),  32'd0);
    chk("single_occ",   32'(occupancy),     32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("single_cnt1",  32'(cnt_port1),     32'd1);
    chk("single_cnt2",  32'(cnt_port2),     32'd0);
    chk("single_empty", 32'(bus.out_valid), 32'd0);

    // Dest 6: onward.
    bus.in_valid = 1'b1; bus.in_data = 11'h6FF;
    tick();
    bus.in_valid = 1'b0;
    chk("onward_ctrl", 32'(bus.out_ctrl), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("onward_cnt2", 32'(cnt_port2), 32'd1);
    chk("onward_cnt1", 32'(cnt_port1), 32'd1);

    // Fill to full with out_ready low, then offer a fifth flit.
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = fill[i];
      tick();
    end
    chk("full_occ",      32'(occupancy),    32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_data = 11'h454;
    tick();
    chk("full_reject_occ", 32'(occupancy), 32'd4);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_data%0d", i), 32'(bus.out_data), 32'(fill[i]));
      tick();
    end
    bus.out_ready = 1'b0;
    chk("drain_empty", 32'(bus.out_valid), 32'd0);
    chk("drain_occ",   32'(occupancy),     32'd0);
    chk("drain_cnt1",  32'(cnt_port1),     32'd3);
    chk("drain_cnt2",  32'(cnt_port2),     32'd3);

    // Streaming: one flit per cycle, alternating dest 0 and dest 7.
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sflit = {(i % 2 == 1) ? 3'd7 : 3'd0, 8'(i)};
      bus.in_data = sflit;
      tick();
      chk($sformatf("stream_occ%0d", i),  32'(occupancy),    32'd1);
      chk($sformatf("stream_data%0d", i), 32'(bus.out_data), 32'(sflit));
    end
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    chk("stream_cnt1", 32'(cnt_port1), 32'd13);
    chk("stream_cnt2", 32'(cnt_port2), 32'd13);
    chk("stream_occ_end", 32'(occupancy), 32'd0);

    // Backpressure: head must hold while stalled.
    bus.in_valid = 1'b1; bus.in_data = 11'h7AB;
    tick();
    bus.in_data = 11'h0CD;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_data%0d", i), 32'(bus.out_data), 32'h7AB);
      chk($sformatf("stall_ctrl%0d", i), 32'(bus.out_ctrl), 32'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    chk("bp_first", 32'(bus.out_data), 32'h7AB);
    tick();
    chk("bp_second", 32'(bus.out_data), 32'h0CD);
    chk("bp_second_ctrl", 32'(bus.out_ctrl), 32'd0);
    tick();
    bus.out_ready = 1'b0;
    chk("bp_cnt1", 32'(cnt_port1), 32'd14);
    chk("bp_cnt2", 32'(cnt_port2), 32'd14);

    // Asynchronous reset with three flits queued.
    bus.in_valid = 1'b1;
    bus.in_data = 11'h111; tick();
    bus.in_data = 11'h222; tick();
    bus.in_data = 11'h333; tick();
    bus.in_valid = 1'b0;
    chk("pre_rst_occ", 32'(occupancy), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_occ",       32'(occupancy),     32'd0);
    chk("arst_cnt1",      32'(cnt_port1),     32'd0);
    chk("arst_cnt2",      32'(cnt_port2),     32'd0);
    chk("arst_in_ready",  32'(bus.in_ready),  32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b1; bus.in_data = 11'h2EE;
    tick();
    bus.in_valid = 1'b0;
    chk("post_rst_data", 32'(bus.out_data), 32'h2EE);
    chk("post_rst_ctrl", 32'(bus.out_ctrl), 32'd1);
    chk("post_rst_occ",  32'(occupancy),    32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("post_rst_cnt2", 32'(cnt_port2), 32'd1);
    chk("post_rst_cnt1", 32'(cnt_port1), 32'd0);
    chk("post_rst_empty", 32'(bus.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/route_compute_2.md
# route_compute_2

Route-compute and input-buffer stage that sits directly upstream of the two-way split in each router node. It accepts 11-bit flits on a valid/ready channel and buffers them in a small FIFO. For each flit it computes the 1-bit steering control from the destination field, then presents the data and control together to the split stage as one transfer. Per-direction flit counters are kept for debug and performance visibility.

## Interface
Parameters:
- `NODE_ID`, 3'd0: this node's address.
- `LEVEL_MASK`, 3'b110: address bits that identify this node's subtree.
- `DEPTH`, 4: FIFO entries; a power of 2, at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `_RESET`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream flit present.
- `in_ready`  out  1  block can accept a flit.
- `in_data`  in  11  flit: [10:8] destination id, [7:0] payload.
- `out_valid`  out  1  head flit and control are valid.
- `out_ready`  in  1  split stage accepts.
- `out_data`  out  11  head flit, unmodified.
- `out_ctrl`  out  1  0 = port 1 (local subtree), 1 = port 2 (onward).
- `occupancy`  out  $clog2(DEPTH)+1  number of flits stored.
- `cnt_port1`, `cnt_port2`  out  16  flits delivered per direction.

## Operation
- A push happens when `in_valid && in_ready`. A pop happens when `out_valid && out_ready`.
- `in_ready = (occupancy != DEPTH)`.
  - `in_ready` is low when full, even if a pop occurs in the same cycle. No full-bypass.
- `out_valid = (occupancy != 0)`. `out_data` is the FIFO head.
- `out_ctrl = ((head[10:8] & LEVEL_MASK) == (NODE_ID & LEVEL_MASK)) ? 0 : 1`.
  - Combinational from the head entry.
  - Stable together with `out_data` for as long as `out_valid && !out_ready`.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally at DEPTH.
- Occupancy update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together (possible only when not full): unchanged.
  - Push and pop when empty cannot occur, because there is no empty bypass.
- Counters:
  - On each pop, `cnt_port1` increments if `out_ctrl == 0`, otherwise `cnt_port2` increments.
  - Counters are 16-bit and wrap from 16'hFFFF to 0.
- Flit order is preserved. Data is never altered.

## Timing
- Reset (async assert, sync-to-clk deassert handled externally):
  - Pointers, `occupancy`, and both counters = 0.
  - Therefore `out_valid` = 0 and `in_ready` = 1.
  - `out_data` and `out_ctrl` are don't-care while `out_valid` = 0.
- Reset asserted mid-operation: all stored flits are discarded immediately. No partial transfer completes.
- Latency: a flit pushed at edge N is presented with `out_valid` = 1 after edge N (cycle N+1) if the FIFO was empty.
- Throughput: 1 flit per cycle sustained when `out_ready` is held high and the FIFO is not full.
- Handshake rules:
  - `out_valid` never deasserts without a pop.
  - `in_ready` may toggle freely. Upstream must hold `in_data` while `in_valid && !in_ready`.

## Structure
- Package `noc_pkg`:
  - `FLIT_W` = 11.
  - `DEST_HI` = 10, `DEST_LO` = 8.
  - `typedef logic [FLIT_W-1:0] flit_t`.
  - Function `route_bit(dest, node_id, mask)`, shared with other router stages.
- Sub-module `flit_fifo #(DEPTH)`: register-array sync FIFO with push/pop/full/empty/count.
- The top level adds route compute and counters.

## Test plan
- Single flit: `NODE_ID` = 0, mask = 3'b110, flit 11'h1A5 (dest 1).
  - `out_valid` next cycle, `out_ctrl` = 0.
  - `cnt_port1` = 1 after pop.
- Onward route: flit with dest 6 (11'h6FF) → `out_ctrl` = 1, `cnt_port2` increments.
- Fill with `out_ready` = 0: push 4 flits.
  - `occupancy` = 4 and `in_ready` = 0.
  - A 5th `in_valid` is not accepted.
  - Release `out_ready`: the 4 flits exit in order.
- Streaming with `in_valid` and `out_ready` held high for 20 cycles with alternating dest 0/7:
  - 1 flit per cycle.
  - Occupancy stays at 1.
  - `cnt_port1` = `cnt_port2` = 10 afterwards.
- Backpressure stability: stall `out_ready` for 5 cycles with 2 flits queued → `out_data` and `out_ctrl` stay constant throughout.
- Reset mid-stream: assert `_RESET` with 3 flits queued.
  - Immediately `out_valid` = 0, `occupancy` = 0, counters = 0.
  - After release, a new flit flows normally.
